// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared state encoding, default width and counter sizing for the
//            bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_bit_cell.sv
`default_nettype none
// ============================================================================
// Module   : sub_bit_cell
// Purpose  : Combinational 1-bit subtract cell: full adder on a, ~b, cin.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic b_n;
    logic p;

    assign b_n  = ~b;
    assign p    = a ^ b_n;
    assign s    = p ^ cin;
    assign cout = (a & b_n) | (p & cin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial A - B, LSB first, one registered full-adder cell.
//            SERIAL_SUBTRACTOR_OVF_EN enables the signed-overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_switch_a,
    input  logic [WIDTH-1:0] i_switch_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    // The final sum bit goes straight into the result, so the shift register
    // only ever needs to hold the first WIDTH-1 bits.
    logic [WIDTH-2:0]   diff_q, diff_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               borrow_q, borrow_d;

    logic               cell_s;
    logic               cell_cout;

    sub_bit_cell u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (c_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        res_d    = res_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sa_d    = i_switch_a;
                    sb_d    = i_switch_b;
                    c_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d   = {1'b0, sa_q[WIDTH-1:1]};
                sb_d   = {1'b0, sb_q[WIDTH-1:1]};
                diff_d = {cell_s, diff_q[WIDTH-2:1]};
                c_d    = cell_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    res_d    = {cell_s, diff_q};
                    borrow_d = ~cell_cout;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf_q, ovf_d;

    // On the final SHIFT cycle c_q is the carry into the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == SHIFT) && (cnt_q == CNT_LAST)) begin
            ovf_d = c_q ^ cell_cout;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_diff   = res_q;
    assign o_borrow = borrow_q;

endmodule
`default_nettype wire
